serial_add_sub: RTL and testbench
=================================

// Module: serial_add_sub
// PURPOSE
//  Parametrised bit-serial adder/subtracter for the SAP datapath ALU path.
//  Captures two WIDTH-bit operands, then processes one bit per clock through a
//  single full-adder cell, LSB first. Produces SUM, CARRY and ZERO flags with a
//  START/BUSY/DONE handshake. Trades latency for one-cell area.
// PARAMETERS
//  WIDTH   8   operand/result width in bits; legal range WIDTH >= 2
// PORTS
//  CLK    in   1      single clock; all state updates on rising edge
//  RST    in   1      synchronous, active-high reset
//  START  in   1      request; sampled only in IDLE or FIN
//  SUB    in   1      0: A+B, 1: A-B; sampled with START
//  A      in   WIDTH  operand A; sampled with START
//  B      in   WIDTH  operand B; sampled with START
//  BUSY   out  1      high while bit-steps are in progress (state RUN)
//  DONE   out  1      one-cycle pulse; result valid
//  SUM    out  WIDTH  result; held from DONE until the next completion or RST
//  CARRY  out  1      carry out of the MSB; for SUB, 1 = no borrow (A >= B unsigned)
//  ZERO   out  1      SUM == 0; updated with SUM
//  OVF    out  1      signed overflow; present only with SERIAL_ADD_SUB_OVF_EN
// BEHAVIOUR
//  Reset: state=IDLE; BUSY, DONE, SUM, CARRY, ZERO and OVF are all 0.
//    The bit counter and shift registers are cleared.
//  States:
//    IDLE -> RUN on START.
//    RUN  -> FIN after the WIDTH-th bit-step.
//    FIN  -> RUN on START, else FIN -> IDLE.
//  Capture edge E0 (START=1 in IDLE/FIN):
//    a_sh <= A;  b_sh <= SUB ? ~B : B;  c <= SUB;  cnt <= 0.
//  RUN edges E1..E_WIDTH, one bit-step each:
//    fa_bit(a_sh[0], b_sh[0], c) gives s, co.
//    sum_sh <= {s, sum_sh[WIDTH-1:1]}; a_sh and b_sh shift right; c <= co; cnt++.
//  Last step (cnt == WIDTH-1):
//    SUM <= {s, sum_sh[WIDTH-1:1]}; CARRY <= co; ZERO <= (that value == 0).
//    State -> FIN.
//  Latency: DONE=1 in the cycle after edge E0+WIDTH. BUSY is high for exactly
//    WIDTH cycles.
//  SUM, CARRY and ZERO change only at the last step. They never show partial
//    results.
//  START while in RUN is ignored; captured operands are unaffected.
//  START in FIN is accepted back-to-back: DONE pulses, and BUSY rises the next cycle.
//  RST mid-operation: on the next edge, return to reset values. No DONE is produced.
//  RST has priority over START.
//  Counter width is $clog2(WIDTH). Arithmetic wraps modulo 2**WIDTH.
// CONFIGURATION
//  SERIAL_ADD_SUB_OVF_EN defined:
//    OVF port exists.
//    At the last step, OVF <= c_in_msb ^ co, where c_in_msb is the carry into
//    bit WIDTH-1 (the c register at that step).
//    OVF is reset to 0 and held like SUM.
//  Macro undefined:
//    No OVF port and no related logic.
//    All other behaviour is identical.
// STRUCTURE
//  serial_add_sub_pkg:
//    typedef enum logic [1:0] {IDLE, RUN, FIN} sas_state_t
//    localparam SAS_ADD = 1'b0, SAS_SUB = 1'b1
//  Sub-module fa_bit: gate-level full adder (A, B, C -> SUM, CARRY).
//    SUM = A^B^C; CARRY = A&B | C&(A^B). Instantiated once.
//  Top level: FSM, counter, three shift registers, output registers.
// TESTING (WIDTH=8)
//  1. RST 2 cycles -> all outputs 0, BUSY=0.
//     Then 35+4A, SUB=0 -> SUM=7F, CARRY=0, ZERO=0.
//     BUSY high 8 cycles; DONE one cycle after edge E0+8.
//  2. FF+01 add -> SUM=00, CARRY=1, ZERO=1, OVF=0.
//     7F+01 add -> SUM=80, CARRY=0, OVF=1.
//  3. 10-20 sub -> SUM=F0, CARRY=0, OVF=0.
//     80-01 sub -> SUM=7F, CARRY=1, OVF=1.
//     05-05 sub -> SUM=00, ZERO=1, CARRY=1.
//  4. START with A=FF, B=FF at step 3 of an in-flight 35+4A -> ignored; SUM=7F.
//     START held high during FIN -> new op begins; two DONE pulses 9 cycles apart.
//  5. RST at step 4 of 12+34 -> next cycle BUSY=0, SUM=0. No DONE follows.
//     Subsequent 01+01 -> SUM=02.
//  6. Build without SERIAL_ADD_SUB_OVF_EN -> cases 1-5 still pass, minus the OVF checks.

Source files
------------

// File: rtl/serial_add_sub_pkg.sv
// Shared types and constants for the bit-serial adder/subtracter.
package serial_add_sub_pkg;

    // Control FSM states: waiting, stepping bits, result just completed
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } sas_state_t;

    // Operation select values for the SUB input
    localparam logic SAS_ADD = 1'b0;
    localparam logic SAS_SUB = 1'b1;

    // A new request is only accepted while no bit-steps are in flight
    function automatic logic sas_can_accept(input sas_state_t st);
        return (st == IDLE) || (st == FIN);
    endfunction

endpackage

// File: rtl/serial_add_sub_fa_bit.sv
// Single full-adder cell; the only arithmetic element of the serial datapath.
module fa_bit (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_sum,
    output logic o_carry
);

    logic w_axb;

    assign w_axb   = i_a ^ i_b;
    assign o_sum   = w_axb ^ i_c;
    assign o_carry = (i_a & i_b) | (i_c & w_axb);

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial WIDTH-bit adder/subtracter, LSB first through one full-adder cell.
// Optional signed-overflow flag OVF is built only when SERIAL_ADD_SUB_OVF_EN
// is defined; the default build has no OVF port.
module serial_add_sub
    import serial_add_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             SUB,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] SUM,
    output logic             CARRY,
    output logic             ZERO
`ifdef SERIAL_ADD_SUB_OVF_EN
    ,
    output logic             OVF
`endif
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    sas_state_t       r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    // Holds the WIDTH-1 most recent sum bits; the newest bit enters at the top
    logic [WIDTH-2:0] r_sum_sh;
    logic             r_c;
    logic [CNT_W-1:0] r_cnt;

    logic             w_s;
    logic             w_co;
    logic [WIDTH-1:0] w_sum_next;
    logic             w_accept;
    logic             w_step;
    logic             w_last;

    fa_bit u_fa (
        .i_a    (r_a_sh[0]),
        .i_b    (r_b_sh[0]),
        .i_c    (r_c),
        .o_sum  (w_s),
        .o_carry(w_co)
    );

    assign w_sum_next = {w_s, r_sum_sh};
    assign w_accept   = START && sas_can_accept(r_state);
    assign w_step     = (r_state == RUN);
    assign w_last     = w_step && (r_cnt == LAST_CNT);

    // Control FSM with registered BUSY level and one-cycle DONE pulse
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (START) begin
                        r_state <= RUN;
                        BUSY    <= 1'b1;
                    end
                end
                RUN: begin
                    if (r_cnt == LAST_CNT) begin
                        r_state <= FIN;
                        BUSY    <= 1'b0;
                        DONE    <= 1'b1;
                    end
                end
                FIN: begin
                    if (START) begin
                        r_state <= RUN;
                        BUSY    <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    BUSY    <= 1'b0;
                end
            endcase
        end
    end

    // Operand capture and per-bit shifting; subtraction is A + ~B + 1
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_sum_sh <= '0;
            r_c      <= 1'b0;
            r_cnt    <= '0;
        end else if (w_accept) begin
            r_a_sh <= A;
            r_b_sh <= (SUB == SAS_SUB) ? ~B : B;
            r_c    <= SUB;
            r_cnt  <= '0;
        end else if (w_step) begin
            r_a_sh   <= r_a_sh >> 1;
            r_b_sh   <= r_b_sh >> 1;
            r_sum_sh <= w_sum_next[WIDTH-1:1];
            r_c      <= w_co;
            r_cnt    <= r_cnt + 1'b1;
        end
    end

    // Result flags load only on the final bit-step so no partial value is visible
    always_ff @(posedge CLK) begin
        if (RST) begin
            SUM   <= '0;
            CARRY <= 1'b0;
            ZERO  <= 1'b0;
        end else if (w_last) begin
            SUM   <= w_sum_next;
            CARRY <= w_co;
            ZERO  <= (w_sum_next == '0);
        end
    end

`ifdef SERIAL_ADD_SUB_OVF_EN
    // Signed overflow: carry into the MSB differs from carry out of it
    always_ff @(posedge CLK) begin
        if (RST) begin
            OVF <= 1'b0;
        end else if (w_last) begin
            OVF <= r_c ^ w_co;
        end
    end
`endif

endmodule

// File: tb/tb_serial_add_sub.sv
// Testbench for serial_add_sub (WIDTH=8): directed table, corner sequences
// and randomized operations checked against an arithmetic reference model.
module tb_serial_add_sub;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         RST;
    logic         START;
    logic         SUB;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         BUSY;
    logic         DONE;
    logic [W-1:0] SUM;
    logic         CARRY;
    logic         ZERO;
`ifdef SERIAL_ADD_SUB_OVF_EN
    logic         OVF;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    serial_add_sub #(.WIDTH(W)) dut (
        .CLK  (CLK),
        .RST  (RST),
        .START(START),
        .SUB  (SUB),
        .A    (A),
        .B    (B),
        .BUSY (BUSY),
        .DONE (DONE),
        .SUM  (SUM),
        .CARRY(CARRY),
        .ZERO (ZERO)
`ifdef SERIAL_ADD_SUB_OVF_EN
        ,
        .OVF  (OVF)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W-1:0] sum;
        logic         carry;
        logic         zero;
        logic         ovf;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values
    function automatic vec_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        vec_t r;
        int ua = int'(a);
        int ub = int'(b);
        int sa = int'($signed(a));
        int sb = int'($signed(b));
        int sr;
        r.a   = a;
        r.b   = b;
        r.sub = sub;
        if (sub) begin
            r.sum   = W'(ua - ub);
            r.carry = (ua >= ub);
            sr      = sa - sb;
        end else begin
            r.sum   = W'(ua + ub);
            r.carry = ((ua + ub) >= (1 << W));
            sr      = sa + sb;
        end
        r.zero = (r.sum == '0);
        r.ovf  = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
        return r;
    endfunction

    // Issue one operation from an IDLE/FIN sample point; returns edges to DONE
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                         output int lat, output int busy_n);
        A = a; B = b; SUB = sub; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        lat = 0; busy_n = 0;
        while (!DONE && lat < 40) begin
            if (BUSY) busy_n++;
            @(posedge CLK); #1;
            lat++;
        end
    endtask

    task automatic run_and_check(input string tag, input vec_t e);
        int lat, busy_n;
        do_op(e.a, e.b, e.sub, lat, busy_n);
        chk({tag, "_latency"}, lat, W);
        chk({tag, "_busy_cycles"}, busy_n, W);
        chk({tag, "_sum"}, SUM, e.sum);
        chk({tag, "_carry"}, CARRY, e.carry);
        chk({tag, "_zero"}, ZERO, e.zero);
`ifdef SERIAL_ADD_SUB_OVF_EN
        chk({tag, "_ovf"}, OVF, e.ovf);
`endif
        @(posedge CLK); #1;
        chk({tag, "_done_pulse"}, DONE, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[6];
        vec_t e;
        int   k, d1, d2, dn;

        tbl[0] = '{8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
        tbl[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b0, 1'b1};
        tbl[5] = '{8'h05, 8'h05, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0};

        RST = 1'b1; START = 1'b0; SUB = 1'b0; A = '0; B = '0;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_done", DONE, 1'b0);
        chk("rst_sum", SUM, '0);
        chk("rst_carry", CARRY, 1'b0);
        chk("rst_zero", ZERO, 1'b0);
`ifdef SERIAL_ADD_SUB_OVF_EN
        chk("rst_ovf", OVF, 1'b0);
`endif

        // Directed vectors
        for (int i = 0; i < 6; i++) begin
            run_and_check($sformatf("vec%0d", i), tbl[i]);
        end

        // START during RUN is ignored
        A = 8'h35; B = 8'h4A; SUB = 1'b0; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (2) begin @(posedge CLK); #1; end
        A = 8'hFF; B = 8'hFF; SUB = 1'b1; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        k = 0;
        while (!DONE && k < 40) begin @(posedge CLK); #1; k++; end
        chk("ignore_start_done_seen", DONE, 1'b1);
        chk("ignore_start_sum", SUM, 8'h7F);
        chk("ignore_start_carry", CARRY, 1'b0);
        @(posedge CLK); #1;
        chk("ignore_start_idle", BUSY, 1'b0);

        // START held through FIN: back-to-back operations
        A = 8'h35; B = 8'h4A; SUB = 1'b0; START = 1'b1;
        k = 0; d1 = -1; d2 = -1;
        while (k < 40) begin
            @(posedge CLK); #1; k++;
            if (DONE) begin d1 = k; break; end
        end
        chk("b2b_first_sum", SUM, 8'h7F);
        A = 8'h01; B = 8'h01;
        @(posedge CLK); #1; k++;
        chk("b2b_busy_rises", BUSY, 1'b1);
        chk("b2b_done_low", DONE, 1'b0);
        START = 1'b0;
        while (k < 80) begin
            @(posedge CLK); #1; k++;
            if (DONE) begin d2 = k; break; end
        end
        chk("b2b_done_spacing", d2 - d1, 9);
        chk("b2b_second_sum", SUM, 8'h02);
        @(posedge CLK); #1;

        // Reset mid-operation
        A = 8'h12; B = 8'h34; SUB = 1'b0; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (3) begin @(posedge CLK); #1; end
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        chk("midrst_busy", BUSY, 1'b0);
        chk("midrst_sum", SUM, 8'h00);
        chk("midrst_done", DONE, 1'b0);
        dn = 0;
        repeat (12) begin
            @(posedge CLK); #1;
            if (DONE) dn++;
        end
        chk("midrst_no_done", dn, 0);
        run_and_check("after_rst", model(8'h01, 8'h01, 1'b0));

        // Randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            e = model(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
                      1'($urandom_range(0, 1)));
            run_and_check($sformatf("rand%0d", i), e);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
